lcd_text_driver: RTL and testbench

LCD_TEXT_DRIVER -- requirements
Module: lcd_text_driver

---
 rtl/lcd_pkg.sv | 55 +++++
 rtl/lcd_text_driver_if.sv | 30 +++
 rtl/lcd_slot_timer.sv | 37 +++
 rtl/lcd_text_driver.sv | 139 +++++++++++++
 tb/tb_lcd_text_driver.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 text driver.
// FSM encoding, LCD command bytes and a few character codes.
package lcd_pkg;

    typedef enum logic [3:0] {
        PWR_WAIT,
        FUNC_SET,
        DISP_ON,
        ENTRY,
        CLEAR,
        CLR_WAIT,
        L1_ADDR,
        L1_CHAR,
        L2_ADDR,
        L2_CHAR
    } lcd_state_e;

    localparam logic [7:0] CMD_FUNC_SET = 8'h38;
    localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
    localparam logic [7:0] CMD_ENTRY    = 8'h06;
    localparam logic [7:0] CMD_CLEAR    = 8'h01;
    localparam logic [7:0] CMD_L1_ADDR  = 8'h80;
    localparam logic [7:0] CMD_L2_ADDR  = 8'hC0;

    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_COLON = 8'h3A;
    localparam logic [7:0] CH_A     = 8'h41;
    localparam logic [7:0] CH_P     = 8'h50;
    localparam logic [7:0] CH_M     = 8'h4D;

    // Idle states put nothing on the bus and never pulse E.
    function automatic logic is_write(input lcd_state_e s);
        return !(s == PWR_WAIT || s == CLR_WAIT);
    endfunction

    function automatic logic is_char(input lcd_state_e s);
        return (s == L1_CHAR || s == L2_CHAR);
    endfunction

    function automatic logic [7:0] cmd_byte(input lcd_state_e s);
        logic [7:0] b;
        b = 8'h00;
        case (s)
            FUNC_SET: b = CMD_FUNC_SET;
            DISP_ON:  b = CMD_DISP_ON;
            ENTRY:    b = CMD_ENTRY;
            CLEAR:    b = CMD_CLEAR;
            L1_ADDR:  b = CMD_L1_ADDR;
            L2_ADDR:  b = CMD_L2_ADDR;
            default:  b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/lcd_text_driver_if.sv
// Text buffer in, HD44780 parallel bus and frame pulse out.
// master = the driver, slave = the host/panel side.
interface lcd_text_driver_if;

    logic [255:0] LCD_DATA;
    logic         LCD_E;
    logic         LCD_RS;
    logic         LCD_RW;
    logic [7:0]   LCD_DB;
    logic         FRAME_DONE;

    modport master (
        input  LCD_DATA,
        output LCD_E,
        output LCD_RS,
        output LCD_RW,
        output LCD_DB,
        output FRAME_DONE
    );

    modport slave (
        output LCD_DATA,
        input  LCD_E,
        input  LCD_RS,
        input  LCD_RW,
        input  LCD_DB,
        input  FRAME_DONE
    );

endinterface

// File: rtl/lcd_slot_timer.sv
// Free-running slot timebase: cnt counts 0..TICK_CYCLES-1 and wraps.
// e_window marks the cycles where a write slot raises E.
module lcd_slot_timer #(
    parameter int TICK_CYCLES = 100
) (
    input  logic clk,
    input  logic rst,
    output logic slot_start,
    output logic slot_end,
    output logic e_window
);

    localparam int CW = $clog2(TICK_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);
    localparam logic [CW-1:0] HALF = CW'(TICK_CYCLES / 2);
    localparam logic [CW-1:0] ONE  = CW'(1);
    localparam logic [CW-1:0] ZERO = '0;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        slot_start = (cnt_q == ZERO);
        slot_end   = (cnt_q == LAST);
        e_window   = (cnt_q >= ONE) && (cnt_q <= HALF);
        cnt_d      = slot_end ? ZERO : cnt_q + ONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= ZERO;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/lcd_text_driver.sv
// HD44780 8-bit driver: init sequence, then refreshes both 16-char lines
// forever from a per-frame snapshot of the 32-char text buffer.
module lcd_text_driver
    import lcd_pkg::*;
#(
    parameter int TICK_CYCLES   = 100,
    parameter int POWERUP_SLOTS = 200,
    parameter int CLEAR_SLOTS   = 20
) (
    input  logic               CLK,
    input  logic               RESET,
    lcd_text_driver_if.master  bus
);

    localparam logic [15:0] PWR_LAST = 16'(POWERUP_SLOTS - 1);
    localparam logic [15:0] CLR_LAST = 16'(CLEAR_SLOTS - 1);

    logic slot_start;
    logic slot_end;
    logic e_window;

    lcd_slot_timer #(
        .TICK_CYCLES(TICK_CYCLES)
    ) u_timer (
        .clk       (CLK),
        .rst       (RESET),
        .slot_start(slot_start),
        .slot_end  (slot_end),
        .e_window  (e_window)
    );

    lcd_state_e   state_q, state_d;
    logic [15:0]  slot_cnt_q, slot_cnt_d;
    logic [3:0]   char_q, char_d;
    logic [255:0] snap_q, snap_d;
    logic         e_q, e_d;
    logic         rs_q, rs_d;
    logic [7:0]   db_q, db_d;
    logic         done_q, done_d;

    logic [4:0]   ch_idx;
    logic [7:0]   ch_byte;

    always_comb begin
        ch_idx  = {state_q == L2_CHAR, char_q};
        ch_byte = snap_q[{ch_idx, 3'b000} +: 8];
    end

    always_comb begin
        state_d    = state_q;
        slot_cnt_d = slot_cnt_q;
        char_d     = char_q;
        snap_d     = snap_q;
        rs_d       = rs_q;
        db_d       = db_q;
        e_d        = is_write(state_q) && e_window;
        done_d     = 1'b0;

        // One snapshot per frame keeps both lines coherent.
        if (slot_start && state_q == L1_ADDR) begin
            snap_d = bus.LCD_DATA;
        end

        if (slot_start && is_write(state_q)) begin
            rs_d = is_char(state_q);
            db_d = is_char(state_q) ? ch_byte : cmd_byte(state_q);
        end

        if (slot_end) begin
            unique case (state_q)
                PWR_WAIT: begin
                    if (slot_cnt_q == PWR_LAST) begin
                        slot_cnt_d = '0;
                        state_d    = FUNC_SET;
                    end else begin
                        slot_cnt_d = slot_cnt_q + 16'd1;
                    end
                end
                FUNC_SET: state_d = DISP_ON;
                DISP_ON:  state_d = ENTRY;
                ENTRY:    state_d = CLEAR;
                CLEAR:    state_d = CLR_WAIT;
                CLR_WAIT: begin
                    if (slot_cnt_q == CLR_LAST) begin
                        slot_cnt_d = '0;
                        state_d    = L1_ADDR;
                    end else begin
                        slot_cnt_d = slot_cnt_q + 16'd1;
                    end
                end
                L1_ADDR:  state_d = L1_CHAR;
                L1_CHAR: begin
                    char_d = char_q + 4'd1;
                    if (char_d == 4'd0) begin
                        state_d = L2_ADDR;
                    end
                end
                L2_ADDR:  state_d = L2_CHAR;
                L2_CHAR: begin
                    char_d = char_q + 4'd1;
                    if (char_d == 4'd0) begin
                        state_d = L1_ADDR;
                        done_d  = 1'b1;
                    end
                end
                default:  state_d = PWR_WAIT;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= PWR_WAIT;
            slot_cnt_q <= '0;
            char_q     <= '0;
            snap_q     <= '0;
            e_q        <= 1'b0;
            rs_q       <= 1'b0;
            db_q       <= 8'h00;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            slot_cnt_q <= slot_cnt_d;
            char_q     <= char_d;
            snap_q     <= snap_d;
            e_q        <= e_d;
            rs_q       <= rs_d;
            db_q       <= db_d;
            done_q     <= done_d;
        end
    end

    assign bus.LCD_E      = e_q;
    assign bus.LCD_RS     = rs_q;
    assign bus.LCD_RW     = 1'b0;
    assign bus.LCD_DB     = db_q;
    assign bus.FRAME_DONE = done_q;

endmodule

// File: tb/tb_lcd_text_driver.sv
// Directed bench for lcd_text_driver with a short timebase
// (4 cycles/slot, 2 power-up slots, 2 clear slots).
module tb_lcd_text_driver;
    import lcd_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    lcd_text_driver_if bus();

    lcd_text_driver #(
        .TICK_CYCLES  (4),
        .POWERUP_SLOTS(2),
        .CLEAR_SLOTS  (2)
    ) dut (
        .CLK  (clk),
        .RESET(rst),
        .bus  (bus.master)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = -1;
    logic e_prev = 1'b0;
    logic rw_hi = 1'b0;

    int         pcyc[$];
    logic       prs[$];
    logic [7:0] pdb[$];
    int         fcyc[$];

    int         ecyc[72];
    logic       ers[72];
    logic [7:0] edb[72];
    int         n_exp;

    logic [7:0]   l1[16];
    logic [7:0]   l2[16];
    logic [255:0] text;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int target);
        for (int k = 0; k < 2000 && cyc < target; k++) @(negedge clk);
        if (cyc < target) chk("timeout", cyc, target);
    endtask

    task automatic add_exp(input int slot, input logic rs,
                           input logic [7:0] db);
        ecyc[n_exp] = 4 * slot + 1;
        ers[n_exp]  = rs;
        edb[n_exp]  = db;
        n_exp++;
    endtask

    // Cycle 0 is the first edge sampled with RESET low.
    always @(posedge clk) begin : mon
        logic r;
        r = rst;
        #1;
        if (r) begin
            cyc = -1;
        end else begin
            cyc = cyc + 1;
            if (bus.LCD_E && !e_prev) begin
                pcyc.push_back(cyc);
                prs.push_back(bus.LCD_RS);
                pdb.push_back(bus.LCD_DB);
            end
            if (bus.FRAME_DONE) fcyc.push_back(cyc);
            if (bus.LCD_RW) rw_hi = 1'b1;
        end
        e_prev = bus.LCD_E;
    end

    initial begin
        // Line 2 reads "     AM 12:34:56"; line 1 is filler with 'A' at col 5.
        l2 = '{8'h20, 8'h20, 8'h20, 8'h20, 8'h20, 8'h41, 8'h4D, 8'h20,
               8'h31, 8'h32, 8'h3A, 8'h33, 8'h34, 8'h3A, 8'h35, 8'h36};
        for (int i = 0; i < 16; i++) l1[i] = 8'h60 + 8'(i);
        l1[5] = 8'h41;
        for (int i = 0; i < 16; i++) begin
            text[8*i +: 8]      = l1[i];
            text[8*(16+i) +: 8] = l2[i];
        end
        bus.LCD_DATA = text;

        n_exp = 0;
        add_exp(2, 1'b0, 8'h38);
        add_exp(3, 1'b0, 8'h0C);
        add_exp(4, 1'b0, 8'h06);
        add_exp(5, 1'b0, 8'h01);
        for (int f = 0; f < 2; f++) begin
            add_exp(8 + 34*f, 1'b0, 8'h80);
            for (int i = 0; i < 16; i++)
                add_exp(9 + 34*f + i, 1'b1,
                        (f == 1 && i == 5) ? 8'h50 : l1[i]);
            add_exp(25 + 34*f, 1'b0, 8'hC0);
            for (int i = 0; i < 16; i++)
                add_exp(26 + 34*f + i, 1'b1, l2[i]);
        end

        repeat (3) @(negedge clk);
        chk("rst_e",    32'(bus.LCD_E), 0);
        chk("rst_rs",   32'(bus.LCD_RS), 0);
        chk("rst_rw",   32'(bus.LCD_RW), 0);
        chk("rst_db",   32'(bus.LCD_DB), 0);
        chk("rst_done", 32'(bus.FRAME_DONE), 0);
        rst = 1'b0;

        // Inside L1_CHAR slot 2 of the first frame.
        wait_cyc(45);
        text[47:40] = 8'h50;
        bus.LCD_DATA = text;

        wait_cyc(304);
        chk("n_pulse", pcyc.size(), 72);
        for (int i = 0; i < 72 && i < pcyc.size(); i++) begin
            chk($sformatf("p%0d_cyc", i), pcyc[i], ecyc[i]);
            chk($sformatf("p%0d_rs", i), 32'(prs[i]), 32'(ers[i]));
            chk($sformatf("p%0d_db", i), 32'(pdb[i]), 32'(edb[i]));
        end
        chk("n_done", fcyc.size(), 2);
        if (fcyc.size() >= 2) begin
            chk("done0_cyc", fcyc[0], 167);
            chk("done1_cyc", fcyc[1], 303);
            chk("done_gap", fcyc[1] - fcyc[0], 136);
        end
        chk("rw_never_hi", 32'(rw_hi), 0);

        // Third frame, L2_CHAR slot with E high.
        wait_cyc(381);
        chk("pre_rst_e", 32'(bus.LCD_E), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_e",  32'(bus.LCD_E), 0);
        chk("mid_rst_db", 32'(bus.LCD_DB), 0);
        chk("mid_rst_rs", 32'(bus.LCD_RS), 0);
        rst = 1'b0;
        pcyc.delete();
        prs.delete();
        pdb.delete();
        fcyc.delete();

        wait_cyc(12);
        chk("re_n_pulse", pcyc.size(), 1);
        if (pcyc.size() >= 1) begin
            chk("re_p0_cyc", pcyc[0], 9);
            chk("re_p0_rs", 32'(prs[0]), 0);
            chk("re_p0_db", 32'(pdb[0]), 32'h38);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
